// File: rtl/magia_pkg.sv
// Shared types and default parameters for the MAGIA boot controller.
package magia_pkg;

    localparam int unsigned N_TILES_DEFAULT      = 4;
    localparam int unsigned HOLD_CYCLES_DEFAULT  = 8;
    localparam int unsigned SLEEP_STABLE_DEFAULT = 4;
    localparam int unsigned TIMEOUT_W_DEFAULT    = 32;
    localparam int unsigned BOOT_ADDR_W          = 32;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        ENABLE,
        RUN,
        FINISH
    } magia_boot_state_e;

endpackage

// File: rtl/magia_boot_ctrl_if.sv
// Mesh-side boot signals between the controller (master) and a MAGIA tile array (slave).
interface magia_boot_ctrl_if
    import magia_pkg::*;
#(
    parameter int unsigned N_TILES = N_TILES_DEFAULT
);

    logic                   tile_rst_n;
    logic                   tile_enable;
    logic                   fetch_enable;
    logic [BOOT_ADDR_W-1:0] boot_addr;
    logic [N_TILES-1:0]     core_sleep;

    modport master (
        output tile_rst_n,
        output tile_enable,
        output fetch_enable,
        output boot_addr,
        input  core_sleep
    );

    modport slave (
        input  tile_rst_n,
        input  tile_enable,
        input  fetch_enable,
        input  boot_addr,
        output core_sleep
    );

endinterface

// File: rtl/magia_sleep_filter.sv
// Per-tile debounce: a tile is done after SLEEP_STABLE consecutive sleeping RUN cycles.
module magia_sleep_filter #(
    parameter int unsigned SLEEP_STABLE = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_flag,
    input  logic clear_cnt,
    input  logic en,
    input  logic sleep,
    output logic done
);

    localparam int unsigned CNT_W = $clog2(SLEEP_STABLE + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clear_cnt) begin
            cnt_q <= '0;
        end else if (en) begin
            if (!sleep) begin
                cnt_q <= '0;
            end else if (cnt_q != CNT_W'(SLEEP_STABLE)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Flag is sticky: only reset or a newly accepted launch clears it.
    always_ff @(posedge clk) begin
        if (rst || clear_flag) begin
            done <= 1'b0;
        end else if (en && sleep && (cnt_q == CNT_W'(SLEEP_STABLE - 1))) begin
            done <= 1'b1;
        end
    end

endmodule

// File: rtl/magia_boot_ctrl.sv
// MAGIA mesh boot sequencer: reset hold, tile enable, fetch enable, and
// completion by per-tile sleep detection or RUN-cycle timeout.
module magia_boot_ctrl
    import magia_pkg::*;
#(
    parameter int unsigned N_TILES      = N_TILES_DEFAULT,
    parameter int unsigned HOLD_CYCLES  = HOLD_CYCLES_DEFAULT,
    parameter int unsigned SLEEP_STABLE = SLEEP_STABLE_DEFAULT,
    parameter int unsigned TIMEOUT_W    = TIMEOUT_W_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [BOOT_ADDR_W-1:0] boot_addr_i,
    input  logic [TIMEOUT_W-1:0]   timeout_i,
    input  logic [N_TILES-1:0]     core_sleep_i,
    output logic                   tile_rst_no,
    output logic                   tile_enable_o,
    output logic                   fetch_enable_o,
    output logic [BOOT_ADDR_W-1:0] boot_addr_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   timeout_o,
    output logic [N_TILES-1:0]     tiles_done_o,
    output logic [TIMEOUT_W-1:0]   run_cycles_o
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    magia_boot_state_e    state_q, state_d;
    logic [HOLD_W-1:0]    hold_q;
    logic [TIMEOUT_W-1:0] run_inc;
    logic                 start_ok, all_done, tmo_hit, done_d, tmo_d;

    assign start_ok = (state_q == IDLE) && start_i;
    assign all_done = &tiles_done_o;
    assign run_inc  = (&run_cycles_o) ? run_cycles_o : run_cycles_o + TIMEOUT_W'(1);
    // Timeout compares the post-increment count so FINISH follows RUN cycle timeout_i.
    assign tmo_hit  = (timeout_i != '0) && (run_inc == timeout_i);

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        case (state_q)
            IDLE:     if (start_i) state_d = RST_HOLD;
            RST_HOLD: if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) state_d = ENABLE;
            ENABLE:   state_d = RUN;
            RUN: begin
                if (all_done) begin
                    state_d = FINISH;
                    done_d  = 1'b1;
                end else if (tmo_hit) begin
                    state_d = FINISH;
                    tmo_d   = 1'b1;
                end
            end
            FINISH:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (abort_i && (state_q != IDLE)) begin
            state_d = IDLE;
            done_d  = 1'b0;
            tmo_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= (state_q == RST_HOLD) ? hold_q + HOLD_W'(1) : '0;
        end
    end

    // Mesh controls are registered from the next state so they track state_q exactly.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tile_rst_no    <= 1'b0;
            tile_enable_o  <= 1'b0;
            fetch_enable_o <= 1'b0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            timeout_o      <= 1'b0;
            boot_addr_o    <= '0;
            run_cycles_o   <= '0;
        end else begin
            tile_rst_no    <= state_d inside {ENABLE, RUN, FINISH};
            tile_enable_o  <= state_d inside {ENABLE, RUN, FINISH};
            fetch_enable_o <= (state_d == RUN);
            busy_o         <= (state_d != IDLE);
            done_o         <= done_d;
            timeout_o      <= tmo_d;
            if (start_ok) begin
                boot_addr_o  <= boot_addr_i;
                run_cycles_o <= '0;
            end else if (state_q == RUN) begin
                run_cycles_o <= run_inc;
            end
        end
    end

    for (genvar i = 0; i < N_TILES; i++) begin : g_tile
        magia_sleep_filter #(
            .SLEEP_STABLE (SLEEP_STABLE)
        ) u_filter (
            .clk        (clk_i),
            .rst        (rst_i),
            .clear_flag (start_ok),
            .clear_cnt  (state_q == ENABLE),
            .en         (state_q == RUN),
            .sleep      (core_sleep_i[i]),
            .done       (tiles_done_o[i])
        );
    end

endmodule

// File: tb/tb_magia_boot_ctrl.sv
// Self-checking bench for magia_boot_ctrl: directed scenario table, hand-written
// abort/reset sequences, and randomized sleep patterns against a window-based model.
module tb_magia_boot_ctrl;

    localparam int unsigned NT     = 4;
    localparam int unsigned HOLD   = 8;
    localparam int unsigned STABLE = 4;
    localparam int unsigned TW     = 32;
    localparam int unsigned MAXK   = 200;
    localparam int unsigned NEVER  = 100000;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [31:0]   boot_addr;
    logic [TW-1:0] timeout;
    logic          busy, done, tmo;
    logic [NT-1:0] tiles;
    logic [TW-1:0] runc;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    bit pat [NT][MAXK];

    magia_boot_ctrl_if #(.N_TILES(NT)) mesh ();

    always #5 clk = ~clk;

    magia_boot_ctrl #(
        .N_TILES      (NT),
        .HOLD_CYCLES  (HOLD),
        .SLEEP_STABLE (STABLE),
        .TIMEOUT_W    (TW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .abort_i        (abort),
        .boot_addr_i    (boot_addr),
        .timeout_i      (timeout),
        .core_sleep_i   (mesh.core_sleep),
        .tile_rst_no    (mesh.tile_rst_n),
        .tile_enable_o  (mesh.tile_enable),
        .fetch_enable_o (mesh.fetch_enable),
        .boot_addr_o    (mesh.boot_addr),
        .busy_o         (busy),
        .done_o         (done),
        .timeout_o      (tmo),
        .tiles_done_o   (tiles),
        .run_cycles_o   (runc)
    );

    typedef struct {
        logic [31:0]   addr;
        int unsigned   tmo_lim;
        int unsigned   on_k   [NT];
        int unsigned   blip_k [NT];
        int unsigned   blip_n [NT];
        int unsigned   exp_outcome;   // 1 = done pulse, 2 = timeout pulse
        logic [NT-1:0] exp_tiles;
        int unsigned   exp_run;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Model: a tile's flag is set by the edge ending the first RUN cycle that
    // closes a window of STABLE consecutive sleeping RUN cycles.
    function automatic int unsigned first_stable(input int unsigned t);
        for (int unsigned k = STABLE; k < MAXK; k++) begin
            bit ok = 1'b1;
            for (int unsigned j = 0; j < STABLE; j++) if (!pat[t][k-j]) ok = 1'b0;
            if (ok) return k;
        end
        return NEVER;
    endfunction

    function automatic logic [NT-1:0] flags_after(input int unsigned s [NT], input int unsigned m);
        logic [NT-1:0] r = '0;
        for (int unsigned t = 0; t < NT; t++) r[t] = (s[t] <= m);
        return r;
    endfunction

    function automatic logic [NT-1:0] pat_at(input int unsigned k);
        logic [NT-1:0] r = '0;
        for (int unsigned t = 0; t < NT; t++) r[t] = pat[t][k];
        return r;
    endfunction

    task automatic build_pattern(input int unsigned on_k [NT], input int unsigned blip_k [NT],
                                 input int unsigned blip_n [NT]);
        for (int unsigned t = 0; t < NT; t++)
            for (int unsigned k = 0; k < MAXK; k++)
                pat[t][k] = ((on_k[t] != 0) && (k >= on_k[t])) ||
                            ((blip_n[t] != 0) && (k >= blip_k[t]) && (k < blip_k[t] + blip_n[t]));
    endtask

    // One full launch; pattern index k is the 1-based RUN cycle number.
    task automatic run_pattern(input logic [31:0] addr, input int unsigned tmo_lim, input bit pre_rand,
                               output int unsigned outcome, output logic [NT-1:0] got_tiles,
                               output int unsigned got_run);
        int unsigned s [NT];
        int unsigned hold_n = 0, en_n = 0, k = 0;
        bit fin = 1'b0;
        outcome = 0;
        got_tiles = '0;
        got_run = 0;
        for (int unsigned t = 0; t < NT; t++) s[t] = first_stable(t);
        start = 1'b1;
        boot_addr = addr;
        timeout = tmo_lim;
        mesh.core_sleep = pre_rand ? NT'($urandom) : '1;
        @(negedge clk);
        start = 1'b0;
        boot_addr = $urandom;
        for (int unsigned c = 0; c < 400 && !fin; c++) begin
            if (done || tmo) begin
                fin = 1'b1;
                outcome = {30'd0, tmo, done};
                got_tiles = tiles;
                got_run = runc;
                check("finish_fetch_low", mesh.fetch_enable, 1'b0);
                check("finish_tile_enable", mesh.tile_enable, 1'b1);
                check("finish_rst_n", mesh.tile_rst_n, 1'b1);
                check("finish_busy", busy, 1'b1);
                check("finish_boot_addr", mesh.boot_addr, addr);
            end else if (!mesh.tile_rst_n) begin
                hold_n++;
                check("hold_tiles_cleared", tiles, '0);
                check("hold_run_cleared", runc, '0);
                mesh.core_sleep = pre_rand ? NT'($urandom) : '1;
            end else if (!mesh.fetch_enable) begin
                en_n++;
                mesh.core_sleep = pre_rand ? NT'($urandom) : '1;
            end else begin
                k++;
                check("run_cycles", runc, k - 1);
                check("tiles_fill", tiles, flags_after(s, k - 1));
                mesh.core_sleep = pat_at(k);
            end
            if (!fin) @(negedge clk);
        end
        check("finish_reached", fin, 1'b1);
        check("hold_len", hold_n, HOLD);
        check("enable_len", en_n, 1);
        @(negedge clk);
        check("idle_busy", busy, 1'b0);
        check("idle_rst_n", mesh.tile_rst_n, 1'b0);
        check("idle_enables", {mesh.tile_enable, mesh.fetch_enable}, 2'b00);
        check("single_pulse", {done, tmo}, 2'b00);
        check("idle_hold_tiles", tiles, got_tiles);
        check("idle_hold_run", runc, got_run);
        check("idle_hold_addr", mesh.boot_addr, addr);
    endtask

    task automatic wait_run(input string name);
        bit ok = 1'b0;
        for (int unsigned c = 0; c < 50 && !ok; c++) begin
            if (mesh.fetch_enable) ok = 1'b1;
            else @(negedge clk);
        end
        check(name, ok, 1'b1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"}, {busy, done, tmo, mesh.tile_rst_n, mesh.tile_enable, mesh.fetch_enable}, '0);
        check({tag, "_addr"}, mesh.boot_addr, '0);
        check({tag, "_tiles"}, tiles, '0);
        check({tag, "_run"}, runc, '0);
    endtask

    initial begin
        int unsigned   outcome, got_run, prev;
        logic [NT-1:0] got_tiles;

        vecs[0] = '{32'hCC00_0080, 0,   '{10, 20, 30, 40}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 4'hF, 44};
        vecs[1] = '{32'h1234_5678, 0,   '{10, 10, 12, 10}, '{0, 0, 5, 0}, '{0, 0, 3, 0}, 1, 4'hF, 16};
        vecs[2] = '{32'hDEAD_0004, 100, '{10, 20, 30, 0},  '{0, 0, 0, 0}, '{0, 0, 0, 0}, 2, 4'h7, 100};
        vecs[3] = '{32'h0000_1000, 54,  '{10, 20, 30, 50}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 4'hF, 54};
        vecs[4] = '{32'hFFFF_FFFC, 0,   '{1, 1, 1, 1},     '{0, 0, 0, 0}, '{0, 0, 0, 0}, 1, 4'hF, 5};

        rst = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        boot_addr = 32'hCAFE_F00D;
        timeout = '0;
        mesh.core_sleep = '1;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", busy, 1'b0);

        for (int unsigned v = 0; v < 5; v++) begin
            build_pattern(vecs[v].on_k, vecs[v].blip_k, vecs[v].blip_n);
            run_pattern(vecs[v].addr, vecs[v].tmo_lim, 1'b0, outcome, got_tiles, got_run);
            check("vec_outcome", outcome, vecs[v].exp_outcome);
            check("vec_tiles", got_tiles, vecs[v].exp_tiles);
            check("vec_run", got_run, vecs[v].exp_run);
        end

        // Start during RUN is ignored; abort drops straight to IDLE without pulses.
        mesh.core_sleep = '0;
        start = 1'b1;
        boot_addr = 32'hA5A5_0000;
        timeout = '0;
        @(negedge clk);
        start = 1'b0;
        wait_run("abort_reach_run");
        repeat (5) @(negedge clk);
        prev = runc;
        start = 1'b1;
        boot_addr = 32'h5A5A_FFFF;
        @(negedge clk);
        start = 1'b0;
        check("ignored_start_addr", mesh.boot_addr, 32'hA5A5_0000);
        check("ignored_start_run", runc, prev + 1);
        check("ignored_start_fetch", mesh.fetch_enable, 1'b1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_ctrl", {busy, mesh.tile_rst_n, mesh.tile_enable, mesh.fetch_enable}, '0);
        check("abort_no_pulse", {done, tmo}, 2'b00);
        @(negedge clk);
        check("abort_stays_idle", {busy, done, tmo}, 3'b000);

        // Reset in the middle of the reset-hold phase.
        start = 1'b1;
        boot_addr = 32'h0BAD_BEEF;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_before_rst", {busy, mesh.tile_rst_n}, 2'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_hold");
        @(negedge clk);
        check("rst_hold_idle", {busy, done, tmo}, 3'b000);

        // Reset mid-RUN discards the done flag already earned by tile 0.
        mesh.core_sleep = 4'b0001;
        start = 1'b1;
        boot_addr = 32'h1357_9BDF;
        @(negedge clk);
        start = 1'b0;
        wait_run("rstrun_reach_run");
        repeat (6) @(negedge clk);
        check("rstrun_tile0_done", tiles, 4'b0001);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_values("rst_run");
        @(negedge clk);
        check("rst_run_no_pulse", {busy, done, tmo}, 3'b000);

        for (int unsigned r = 0; r < 40; r++) begin
            int unsigned   on_k [NT], bk [NT], bn [NT], s [NT];
            int unsigned   t_lim, f_done, e_out, e_run;
            logic [NT-1:0] e_tiles;
            bit any_never = 1'b0;
            for (int unsigned t = 0; t < NT; t++) begin
                on_k[t] = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 80);
                bk[t] = 0;
                bn[t] = 0;
            end
            build_pattern(on_k, bk, bn);
            for (int unsigned t = 0; t < NT; t++)
                for (int unsigned k = 1; k < MAXK; k++)
                    if ($urandom_range(0, 4) == 0) pat[t][k] = 1'b1;
            f_done = 0;
            for (int unsigned t = 0; t < NT; t++) begin
                s[t] = first_stable(t);
                if (s[t] == NEVER) any_never = 1'b1;
                if (s[t] + 1 > f_done) f_done = s[t] + 1;
            end
            t_lim = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(5, 100);
            if (t_lim == 0 && any_never) t_lim = 120;
            if (t_lim != 0 && t_lim < f_done) begin
                e_out = 2;
                e_run = t_lim;
                e_tiles = flags_after(s, t_lim);
            end else begin
                e_out = 1;
                e_run = f_done;
                e_tiles = '1;
            end
            run_pattern($urandom, t_lim, 1'b1, outcome, got_tiles, got_run);
            check("rand_outcome", outcome, e_out);
            check("rand_tiles", got_tiles, e_tiles);
            check("rand_run", got_run, e_run);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/magia_boot_ctrl.md
MAGIA_BOOT_CTRL -- requirements
Module: magia_boot_ctrl

Interface
REQ-001 Parameters SHALL be: N_TILES, default 4, number of tiles controlled; HOLD_CYCLES, default 8, mesh reset hold length; SLEEP_STABLE, default 4, consecutive sleep cycles marking a tile done; TIMEOUT_W, default 32, timeout/counter width.
REQ-002 Ports SHALL be as follows; one clock; reset is synchronous and active-high.
 clk_i  in  1  clock
 rst_i  in  1  synchronous active-high reset
 start_i  in  1  launch request, sampled in IDLE only
 abort_i  in  1  immediate stop
 boot_addr_i  in  32  boot address, latched on accepted start
 timeout_i  in  TIMEOUT_W  RUN cycle limit; 0 disables
 core_sleep_i  in  N_TILES  per-tile core_sleep from mesh
 tile_rst_no  out  1  mesh rst_ni, active-low
 tile_enable_o  out  1  mesh tile_enable
 fetch_enable_o  out  1  mesh fetch_enable
 boot_addr_o  out  32  latched boot address
 busy_o  out  1  state != IDLE
 done_o  out  1  one-cycle pulse, all tiles done
 timeout_o  out  1  one-cycle pulse, timeout expired
 tiles_done_o  out  N_TILES  sticky per-tile done flags
 run_cycles_o  out  TIMEOUT_W  cycles spent in RUN

Function
REQ-003 FSM states SHALL be IDLE, RST_HOLD, ENABLE, RUN, FINISH.
REQ-004 IDLE: start_i=1 SHALL latch boot_addr_i, clear tiles_done_o and run_cycles_o, and enter RST_HOLD next cycle; start_i outside IDLE SHALL be ignored.
REQ-005 RST_HOLD: tile_rst_no SHALL be 0 for exactly HOLD_CYCLES cycles, then ENABLE.
REQ-006 ENABLE: tile_rst_no=1, tile_enable_o=1, fetch_enable_o=0 for exactly one cycle, then RUN.
REQ-007 RUN: tile_rst_no=1, tile_enable_o=1, fetch_enable_o=1; run_cycles_o SHALL increment by 1 per RUN cycle, saturating at all-ones.
REQ-008 Tile i done SHALL be set when core_sleep_i[i] is 1 for SLEEP_STABLE consecutive RUN cycles; any 0 SHALL reset its stable count; flag is sticky until next accepted start.
REQ-009 Stable counters SHALL be cleared on RUN entry; sleep outside RUN SHALL not count.
REQ-010 All tiles_done_o set -> FINISH next cycle with done_o=1 for that one cycle.
REQ-011 timeout_i!=0 and run_cycles_o reaching timeout_i -> FINISH with timeout_o=1 for one cycle.
REQ-012 All-done and timeout in the same cycle SHALL yield done_o=1, timeout_o=0.
REQ-013 FINISH: fetch_enable_o=0, tile_enable_o=1, tile_rst_no=1 for one cycle, then IDLE; tiles_done_o, run_cycles_o and boot_addr_o SHALL hold until next start.
REQ-014 abort_i=1 in any non-IDLE state SHALL enter IDLE next cycle with tile_rst_no=0, no done_o/timeout_o pulse; abort_i takes priority over all other transitions.
REQ-015 IDLE outputs: tile_rst_no=0, tile_enable_o=0, fetch_enable_o=0, busy_o=0.

Reset
REQ-016 rst_i=1 SHALL force IDLE; tile_rst_no=0, tile_enable_o=0, fetch_enable_o=0, boot_addr_o=0, busy_o=0, done_o=0, timeout_o=0, tiles_done_o=0, run_cycles_o=0, all stable counters 0.
REQ-017 rst_i mid-RUN SHALL take effect next edge, discarding progress with no pulses.

Structure
REQ-018 State enum magia_boot_state_e and default parameter constants SHALL live in magia_pkg.
REQ-019 Per-tile debounce SHALL be sub-module magia_sleep_filter (stable counter + sticky flag), instantiated N_TILES times.
REQ-020 Outputs SHALL be registered; no combinational path from inputs to outputs.

Verification (N_TILES=4, HOLD_CYCLES=8, SLEEP_STABLE=4)
REQ-021 start_i pulse, boot_addr_i=0xCC00_0080 -> tile_rst_no low 8 cycles, tile_enable_o high one cycle before fetch_enable_o, boot_addr_o=0xCC00_0080.
REQ-022 tiles sleep at RUN cycles 10,20,30,40, timeout_i=0 -> tiles_done_o fills 0x1,0x3,0x7,0xF; single done_o; run_cycles_o=44.
REQ-023 tile 2 sleeps 3 cycles, wakes, later sleeps 4 -> flag set only after the 4-cycle run.
REQ-024 timeout_i=100, tile 3 never sleeps -> timeout_o at RUN cycle 100, tiles_done_o=0x7, fetch_enable_o drops.
REQ-025 last tile done on cycle run_cycles_o reaches timeout_i -> done_o=1, timeout_o=0.
REQ-026 abort_i in RUN, then rst_i mid-RST_HOLD -> IDLE, tile_rst_no=0, no pulses; start_i during RUN ignored.
